// File: rtl/down_sampler_4_pkg.sv
// Shared sampler definitions: default sample width, samples per symbol, mode encoding.
package down_sampler_4_pkg;

  localparam int DATA_W_DEF = 18;
  localparam int SPS        = 4;
  localparam int IDX_W      = $clog2(SPS);

  typedef enum logic {
    MODE_PICK = 1'b0,
    MODE_IAD  = 1'b1
  } mode_e;

endpackage

// File: rtl/down_sampler_4_if.sv
// Sample-stream bus into the down-sampler and decimated symbol stream out of it.
interface down_sampler_4_if #(
  parameter int DATA_W = 18
) ();

  logic                     sam_en;
  logic signed [DATA_W-1:0] x_in;
  logic [1:0]               phase_sel;
  logic                     mode;
  logic                     resync;
  logic signed [DATA_W-1:0] y;
  logic                     y_valid;
  logic                     sym_start;

  modport master (
    output sam_en, x_in, phase_sel, mode, resync,
    input  y, y_valid, sym_start
  );

  modport slave (
    input  sam_en, x_in, phase_sel, mode, resync,
    output y, y_valid, sym_start
  );

endinterface

// File: rtl/down_sampler_4_sym_phase_counter.sv
// Window index counter: tracks sample index within a 4-sample window, handles resync,
// captures phase/mode at window start and flags the first sample of each symbol.
module sym_phase_counter
  import down_sampler_4_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             sam_en,
  input  logic             resync,
  input  logic [1:0]       phase_sel,
  input  mode_e            mode,
  output logic [IDX_W-1:0] idx,
  output logic [1:0]       phase_eff,
  output mode_e            mode_eff,
  output logic             sym_start
);

  logic [IDX_W-1:0] cnt;
  logic [1:0]       phase_q;
  mode_e            mode_q;
  logic             win_start;

  // Index of the sample presented this cycle; a window start (resync or wrap) uses the live
  // phase/mode so the sample being processed already sees the newly captured settings.
  always_comb begin
    idx       = resync ? '0 : cnt;
    win_start = sam_en && (resync || (cnt == '0));
    phase_eff = win_start ? phase_sel : phase_q;
    mode_eff  = win_start ? mode : mode_q;
  end

  // Counter, phase/mode capture and symbol-start strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      phase_q   <= '0;
      mode_q    <= MODE_PICK;
      sym_start <= 1'b0;
    end else begin
      sym_start <= win_start;
      if (win_start) begin
        phase_q <= phase_sel;
        mode_q  <= mode;
      end
      if (resync)
        cnt <= sam_en ? IDX_W'(1) : '0;
      else if (sam_en)
        cnt <= cnt + IDX_W'(1);
    end
  end

endmodule

// File: rtl/down_sampler_4.sv
// x4 decimator: pick one sample per window at a programmable phase, or output the
// floor-average of the window (integrate-and-dump).
module down_sampler_4
  import down_sampler_4_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input logic              clk,
  input logic              reset,
  down_sampler_4_if.slave  bus
);

  localparam int ACC_W = DATA_W + 2;

  logic [IDX_W-1:0]        idx;
  logic [1:0]              phase_eff;
  mode_e                   mode_eff;
  logic                    sym_start;
  logic signed [ACC_W-1:0] x_ext;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] acc;
  logic signed [DATA_W-1:0] y_q;
  logic                    y_valid_q;

  sym_phase_counter u_cnt (
    .clk       (clk),
    .reset     (reset),
    .sam_en    (bus.sam_en),
    .resync    (bus.resync),
    .phase_sel (bus.phase_sel),
    .mode      (mode_e'(bus.mode)),
    .idx       (idx),
    .phase_eff (phase_eff),
    .mode_eff  (mode_eff),
    .sym_start (sym_start)
  );

  // Running window sum including the current sample.
  always_comb begin
    x_ext = {{(ACC_W-DATA_W){bus.x_in[DATA_W-1]}}, bus.x_in};
    sum   = acc + x_ext;
  end

  // Accumulator and output registers; dropping the two LSBs of the sum is the floor /4.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else begin
      y_valid_q <= 1'b0;
      if (bus.sam_en) begin
        acc <= (idx == '0) ? x_ext : sum;
        if (mode_eff == MODE_PICK) begin
          if (idx == phase_eff) begin
            y_q       <= bus.x_in;
            y_valid_q <= 1'b1;
          end
        end else if (idx == IDX_W'(SPS-1)) begin
          y_q       <= sum[ACC_W-1:2];
          y_valid_q <= 1'b1;
        end
      end
    end
  end

  assign bus.y         = y_q;
  assign bus.y_valid   = y_valid_q;
  assign bus.sym_start = sym_start;

endmodule
